// File: rtl/rr_arb_resp_idx_fifo.sv
// Index FIFO for the arbiter response demux: remembers which input won each
// forwarded request so responses can be steered back in issue order.
module rr_arb_resp_idx_fifo #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdxWidth = 2,
  parameter int unsigned CntWidth = $clog2(Depth+1),
  parameter type         idx_t    = logic [IdxWidth-1:0]
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                push_i,
  input  idx_t                data_i,
  input  logic                pop_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] usage_o,
  output idx_t                head_o
);
  localparam int unsigned            PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0]    LastPtr  = PtrWidth'(Depth-1);
  localparam logic [CntWidth-1:0]    FullCnt  = CntWidth'(Depth);

  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  idx_t                mem_q [Depth];

  // push_i/pop_i arrive already qualified against full/empty by the parent
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrWidth'(1);
    if (pop_i)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrWidth'(1);
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rr_arb_resp_demux.sv
// Routes an in-order response stream back to the arbiter input that issued
// each request, using a FIFO of recorded grant indices.
module rr_arb_resp_demux #(
  parameter int unsigned NumOut    = 4,
  parameter int unsigned DataWidth = 32,
  parameter type         DataType  = logic [DataWidth-1:0],
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned IdxWidth  = (NumOut > 1) ? $clog2(NumOut) : 1,
  parameter int unsigned CntWidth  = $clog2(MaxTrans+1),
  parameter type         idx_t     = logic [IdxWidth-1:0]
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  idx_t                       push_idx_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [CntWidth-1:0]        outstanding_o,
  input  logic                       rsp_valid_i,
  output logic                       rsp_ready_o,
  input  DataType                    rsp_data_i,
  output logic [NumOut-1:0]          rsp_valid_o,
  input  logic [NumOut-1:0]          rsp_ready_i,
  output DataType [NumOut-1:0]       rsp_data_o,
  output logic                       err_o
);
  logic push_ok, pop_ok, full, empty, sel_ready, err_q, err_d;
  idx_t fifo_head, head;

  assign push_ok = push_i & ~full;
  assign pop_ok  = rsp_valid_i & rsp_ready_o;

  rr_arb_resp_idx_fifo #(
    .Depth    (MaxTrans),
    .IdxWidth (IdxWidth),
    .CntWidth (CntWidth),
    .idx_t    (idx_t)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .push_i  (push_ok),
    .data_i  (push_idx_i),
    .pop_i   (pop_ok),
    .full_o  (full),
    .empty_o (empty),
    .usage_o (outstanding_o),
    .head_o  (fifo_head)
  );

  assign head = (NumOut == 1) ? '0 : fifo_head;

  // Valid steering never looks at readies and ready selection never looks at
  // the incoming valid, so no combinational loop can form through upstream.
  always_comb begin
    rsp_valid_o = '0;
    sel_ready   = 1'b0;
    for (int k = 0; k < NumOut; k++) begin
      if (head == IdxWidth'(k)) begin
        rsp_valid_o[k] = rsp_valid_i & ~empty;
        sel_ready      = rsp_ready_i[k];
      end
    end
  end

  assign rsp_ready_o = sel_ready & ~empty;

  always_comb begin
    for (int k = 0; k < NumOut; k++) rsp_data_o[k] = rsp_data_i;
  end

  assign err_d = err_q | (push_i & full) | (rsp_valid_i & empty);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) err_q <= 1'b0;
    else                  err_q <= err_d;
  end

  assign full_o  = full;
  assign empty_o = empty;
  assign err_o   = err_q;

endmodule

// File: tb/tb_rr_arb_resp_demux.sv
// Directed scoreboard bench: instance A (4 outputs, 4 deep) and instance B
// (4 outputs, 3 deep) for the sustained push/pop wrap-around case.
module tb_rr_arb_resp_demux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;

  logic              a_clr = 0, a_push = 0, a_rsp_valid = 0;
  logic [1:0]        a_idx = '0;
  logic [31:0]       a_rsp_data = '0;
  logic [3:0]        a_rsp_ready = '0;
  logic              a_full, a_empty, a_rsp_ready_o, a_err;
  logic [2:0]        a_out;
  logic [3:0]        a_rsp_valid_o;
  logic [3:0][31:0]  a_rsp_data_o;

  logic              b_clr = 0, b_push = 0, b_rsp_valid = 0;
  logic [1:0]        b_idx = '0;
  logic [31:0]       b_rsp_data = '0;
  logic [3:0]        b_rsp_ready = '0;
  logic              b_full, b_empty, b_rsp_ready_o, b_err;
  logic [1:0]        b_out;
  logic [3:0]        b_rsp_valid_o;
  logic [3:0][31:0]  b_rsp_data_o;

  rr_arb_resp_demux #(.NumOut(4), .DataWidth(32), .MaxTrans(4)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .push_i(a_push), .push_idx_i(a_idx),
    .full_o(a_full), .empty_o(a_empty), .outstanding_o(a_out),
    .rsp_valid_i(a_rsp_valid), .rsp_ready_o(a_rsp_ready_o), .rsp_data_i(a_rsp_data),
    .rsp_valid_o(a_rsp_valid_o), .rsp_ready_i(a_rsp_ready), .rsp_data_o(a_rsp_data_o),
    .err_o(a_err)
  );

  rr_arb_resp_demux #(.NumOut(4), .DataWidth(32), .MaxTrans(3)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(b_clr), .push_i(b_push), .push_idx_i(b_idx),
    .full_o(b_full), .empty_o(b_empty), .outstanding_o(b_out),
    .rsp_valid_i(b_rsp_valid), .rsp_ready_o(b_rsp_ready_o), .rsp_data_i(b_rsp_data),
    .rsp_valid_o(b_rsp_valid_o), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data_o),
    .err_o(b_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int qa[$];
  int qb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic a_idle();
    @(posedge clk); #1;
    rst_n = 1; a_clr = 0; a_push = 0; a_rsp_valid = 0;
    @(negedge clk);
  endtask

  task automatic a_clear();
    @(posedge clk); #1;
    a_clr = 1; a_push = 0; a_rsp_valid = 0;
    qa.delete();
    @(negedge clk);
  endtask

  task automatic a_do_push(input int idx, input bit accept);
    @(posedge clk); #1;
    a_clr = 0; a_push = 1; a_idx = 2'(idx); a_rsp_valid = 0;
    if (accept) qa.push_back(idx);
    @(negedge clk);
  endtask

  task automatic a_rsp(input logic [31:0] d, input logic [3:0] rdy);
    int e;
    @(posedge clk); #1;
    a_clr = 0; a_push = 0; a_rsp_valid = 1; a_rsp_data = d; a_rsp_ready = rdy;
    @(negedge clk);
    if (qa.size() == 0) begin
      chk("spur_valid_o", a_rsp_valid_o, 0);
      chk("spur_ready_o", a_rsp_ready_o, 0);
    end else begin
      e = qa[0];
      chk("route_valid_o", a_rsp_valid_o, 64'd1 << e);
      chk("route_ready_o", a_rsp_ready_o, rdy[e]);
      chk("route_data_o", a_rsp_data_o[e], d);
      if (rdy[e]) void'(qa.pop_front());
    end
  endtask

  initial begin
    int e;
    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    chk("rst_full", a_full, 0);
    chk("rst_empty", a_empty, 1);
    chk("rst_outstanding", a_out, 0);
    chk("rst_valid_o", a_rsp_valid_o, 0);
    chk("rst_ready_o", a_rsp_ready_o, 0);
    chk("rst_err", a_err, 0);

    // basic routing
    a_do_push(2, 1); a_do_push(0, 1); a_do_push(3, 1);
    a_idle();
    chk("basic_outstanding", a_out, 3);
    a_rsp(32'hAAAA_0001, 4'hF);
    a_rsp(32'hBBBB_0002, 4'hF);
    a_rsp(32'hCCCC_0003, 4'hF);
    a_idle();
    chk("basic_empty", a_empty, 1);
    chk("basic_err", a_err, 0);

    // fill and overflow
    a_do_push(1, 1); a_do_push(3, 1); a_do_push(0, 1); a_do_push(2, 1);
    a_idle();
    chk("fill_full", a_full, 1);
    chk("fill_outstanding", a_out, 4);
    chk("fill_err", a_err, 0);
    a_do_push(3, 0);
    a_idle();
    chk("ovf_err", a_err, 1);
    chk("ovf_outstanding", a_out, 4);
    for (int i = 0; i < 4; i++) a_rsp(32'h1000 + 32'(i), 4'hF);
    a_idle();
    chk("drain_empty", a_empty, 1);
    chk("ovf_err_sticky", a_err, 1);
    a_clear();
    a_idle();
    chk("clr1_err", a_err, 0);

    // backpressure on head idx 1 while other readies are high
    a_do_push(1, 1);
    for (int i = 0; i < 3; i++) begin
      a_rsp(32'h2222_0000 + 32'(i), 4'b1101);
      chk("bp_outstanding", a_out, 1);
    end
    a_rsp(32'h2222_00FF, 4'hF);
    a_idle();
    chk("bp_empty", a_empty, 1);

    // spurious response while empty
    a_rsp(32'hDEAD_BEEF, 4'hF);
    a_idle();
    chk("spur_err", a_err, 1);
    a_idle();
    chk("spur_err_sticky", a_err, 1);
    a_clear();
    a_idle();
    chk("clr2_err", a_err, 0);
    chk("clr2_empty", a_empty, 1);

    // reset mid-operation
    a_do_push(0, 1); a_do_push(1, 1); a_do_push(2, 1);
    @(posedge clk); #1; rst_n = 0; a_push = 0; a_rsp_valid = 0;
    @(negedge clk);
    qa.delete();
    a_idle();
    chk("mid_rst_outstanding", a_out, 0);
    chk("mid_rst_empty", a_empty, 1);
    chk("mid_rst_err", a_err, 0);
    a_do_push(1, 1);
    a_rsp(32'h0BAD_CAFE, 4'hF);
    a_idle();

    // concurrent push/pop on the 3-deep instance
    @(posedge clk); #1; b_push = 1; b_idx = 2'd1; qb.push_back(1);
    @(posedge clk); #1; b_push = 1; b_idx = 2'd2; qb.push_back(2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      b_push = 1; b_idx = 2'((i + 3) % 4); b_rsp_valid = 1;
      b_rsp_data = 32'h3000 + 32'(i); b_rsp_ready = 4'hF;
      @(negedge clk);
      e = qb.pop_front();
      chk("cc_valid_o", b_rsp_valid_o, 64'd1 << e);
      chk("cc_data_o", b_rsp_data_o[e], 32'h3000 + 32'(i));
      chk("cc_outstanding", b_out, 2);
      qb.push_back((i + 3) % 4);
    end
    @(posedge clk); #1; b_push = 0; b_rsp_valid = 0;
    @(negedge clk);
    chk("cc_final_outstanding", b_out, 2);
    chk("cc_err", b_err, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1; b_rsp_valid = 1; b_rsp_data = 32'h4000 + 32'(i);
      @(negedge clk);
      e = qb.pop_front();
      chk("cc_drain_valid_o", b_rsp_valid_o, 64'd1 << e);
    end
    @(posedge clk); #1; b_rsp_valid = 0;
    @(negedge clk);
    chk("cc_drain_empty", b_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
